// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input from uart_rx and the command/error outputs of uart_cmd_parser.
//   rx_data/rx_ready   : byte and its one-cycle strobe from uart_rx
//   cmd_valid/cmd_ready: command handshake toward the register logic
//   cmd_op/addr/data   : decoded command fields
//   err_*              : one-cycle error pulses
// master = the side that feeds bytes and consumes commands; slave = the parser.
interface uart_cmd_parser_if;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        err_checksum;
  logic        err_timeout;
  logic        err_overrun;

  modport master (
    output rx_data, rx_ready, cmd_ready,
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  err_checksum, err_timeout, err_overrun
  );

  modport slave (
    input  rx_data, rx_ready, cmd_ready,
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    output err_checksum, err_timeout, err_overrun
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles 6-byte frames (SYNC, OP, ADDR, DATA_HI, DATA_LO, CSUM)
// from a uart_rx byte stream and presents good frames on a valid/ready handshake.
// CSUM = OP ^ ADDR ^ DATA_HI ^ DATA_LO. Checksum errors, inter-byte timeouts and
// bytes arriving while a command is pending produce one-cycle error pulses.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : uart_cmd_parser_if.slave (rx byte input, command output, error pulses)
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd86800
) (
  input logic              clk,
  input logic              reset,
  uart_cmd_parser_if.slave bus
);

  typedef enum logic [2:0] {
    S_SYNC, S_OP, S_ADDR, S_DHI, S_DLO, S_CSUM, S_HOLD
  } state_t;

  state_t      state, state_nxt;
  logic [19:0] tmo_cnt, tmo_cnt_nxt;
  logic [7:0]  acc, acc_nxt;
  logic [7:0]  sh_op, sh_addr, sh_dhi, sh_dlo;
  logic [7:0]  cmd_op_q, cmd_addr_q;
  logic [15:0] cmd_data_q;
  logic        err_chk_q, err_tmo_q, err_ovr_q;
  logic        err_chk_nxt, err_tmo_nxt, err_ovr_nxt, load_cmd;
  logic        rx_ready, cmd_ready, sync_hit, csum_ok, tmo_hit;
  logic [7:0]  rx_data;

  // Expiry is checked against the count held this cycle, so the timeout fires
  // on the TIMEOUT_CYCLES-th idle cycle after the last accepted byte.
  function automatic logic tmo_expired(input logic [19:0] cnt);
    return cnt == (TIMEOUT_CYCLES - 20'd1);
  endfunction

  assign rx_data   = bus.rx_data;
  assign rx_ready  = bus.rx_ready;
  assign cmd_ready = bus.cmd_ready;
  assign sync_hit  = (rx_data == SYNC_BYTE);
  assign csum_ok   = (rx_data == acc);
  assign tmo_hit   = tmo_expired(tmo_cnt);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_SYNC;
    else        state <= state_nxt;
  end

  // Next-state logic: one transition per accepted byte, or on timeout/handshake
  always_comb begin
    state_nxt = state;
    case (state)
      S_SYNC: if (rx_ready && sync_hit) state_nxt = S_OP;
      S_OP:   if (rx_ready) state_nxt = S_ADDR; else if (tmo_hit) state_nxt = S_SYNC;
      S_ADDR: if (rx_ready) state_nxt = S_DHI;  else if (tmo_hit) state_nxt = S_SYNC;
      S_DHI:  if (rx_ready) state_nxt = S_DLO;  else if (tmo_hit) state_nxt = S_SYNC;
      S_DLO:  if (rx_ready) state_nxt = S_CSUM; else if (tmo_hit) state_nxt = S_SYNC;
      S_CSUM: begin
        if (rx_ready)     state_nxt = csum_ok ? S_HOLD : S_SYNC;
        else if (tmo_hit) state_nxt = S_SYNC;
      end
      // A byte arriving with the accepting handshake is treated as if already in S_SYNC.
      S_HOLD: if (cmd_ready) state_nxt = (rx_ready && sync_hit) ? S_OP : S_SYNC;
      default: state_nxt = S_SYNC;
    endcase
  end

  // Output/datapath decode: next values of accumulator, counter and error pulses
  always_comb begin
    err_chk_nxt = 1'b0;
    err_tmo_nxt = 1'b0;
    err_ovr_nxt = 1'b0;
    load_cmd    = 1'b0;
    acc_nxt     = acc;
    tmo_cnt_nxt = 20'd0;
    case (state)
      S_SYNC: if (rx_ready && sync_hit) acc_nxt = 8'h00;
      S_OP, S_ADDR, S_DHI, S_DLO: begin
        if (rx_ready)     acc_nxt = acc ^ rx_data;
        else if (tmo_hit) err_tmo_nxt = 1'b1;
        else              tmo_cnt_nxt = tmo_cnt + 20'd1;
      end
      S_CSUM: begin
        if (rx_ready) begin
          if (csum_ok) load_cmd    = 1'b1;
          else         err_chk_nxt = 1'b1;
        end else if (tmo_hit) begin
          err_tmo_nxt = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 20'd1;
        end
      end
      S_HOLD: begin
        if (cmd_ready) begin
          if (rx_ready && sync_hit) acc_nxt = 8'h00;
        end else if (rx_ready) begin
          err_ovr_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt    <= 20'd0;
      acc        <= 8'h00;
      err_chk_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
      cmd_op_q   <= 8'h00;
      cmd_addr_q <= 8'h00;
      cmd_data_q <= 16'h0000;
    end else begin
      tmo_cnt   <= tmo_cnt_nxt;
      acc       <= acc_nxt;
      err_chk_q <= err_chk_nxt;
      err_tmo_q <= err_tmo_nxt;
      err_ovr_q <= err_ovr_nxt;
      if (load_cmd) begin
        cmd_op_q   <= sh_op;
        cmd_addr_q <= sh_addr;
        cmd_data_q <= {sh_dhi, sh_dlo};
      end
    end
  end

  // Shadow registers only matter once a whole frame has been seen, so no reset.
  always_ff @(posedge clk) begin
    if (rx_ready) begin
      case (state)
        S_OP:    sh_op   <= rx_data;
        S_ADDR:  sh_addr <= rx_data;
        S_DHI:   sh_dhi  <= rx_data;
        S_DLO:   sh_dlo  <= rx_data;
        default: ;
      endcase
    end
  end

  // S_HOLD is entered on the same edge that would set a valid flag, so it is the flag.
  assign bus.cmd_valid    = (state == S_HOLD);
  assign bus.cmd_op       = cmd_op_q;
  assign bus.cmd_addr     = cmd_addr_q;
  assign bus.cmd_data     = cmd_data_q;
  assign bus.err_checksum = err_chk_q;
  assign bus.err_timeout  = err_tmo_q;
  assign bus.err_overrun  = err_ovr_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized + directed bench for uart_cmd_parser against a frame-level reference model.
module tb_uart_cmd_parser;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [19:0] TMO  = 20'd40;
  localparam int          TMO_I = 40;

  logic clk;
  logic reset;
  uart_cmd_parser_if bus();

  uart_cmd_parser #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int obs_chk = 0, obs_tmo = 0, obs_ovr = 0;

  // Reference model: frame bytes collected so far, pending command, idle cycles.
  logic [7:0]  m_frm[$];
  bit          m_pend;
  int          m_idle;
  logic [7:0]  m_op, m_addr;
  logic [15:0] m_data;
  bit          m_ec, m_et, m_eo;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [35:0] outs();
    return {bus.cmd_valid, bus.cmd_op, bus.cmd_addr, bus.cmd_data,
            bus.err_checksum, bus.err_timeout, bus.err_overrun};
  endfunction

  function automatic logic [35:0] model_outs();
    return {m_pend, m_op, m_addr, m_data, m_ec, m_et, m_eo};
  endfunction

  task automatic model_reset();
    m_frm.delete();
    m_pend = 0; m_idle = 0;
    m_op = 8'h00; m_addr = 8'h00; m_data = 16'h0000;
    m_ec = 0; m_et = 0; m_eo = 0;
  endtask

  task automatic model_step(input bit rr, input logic [7:0] rd, input bit cr);
    m_ec = 0; m_et = 0; m_eo = 0;
    if (m_pend) begin
      if (cr) begin
        m_pend = 0;
        if (rr && rd == SYNC) begin m_frm.push_back(rd); m_idle = 0; end
      end else if (rr) begin
        m_eo = 1;
      end
    end else if (m_frm.size() == 0) begin
      if (rr && rd == SYNC) begin m_frm.push_back(rd); m_idle = 0; end
    end else if (rr) begin
      m_frm.push_back(rd);
      m_idle = 0;
      if (m_frm.size() == 6) begin
        if ((m_frm[1] ^ m_frm[2] ^ m_frm[3] ^ m_frm[4]) == m_frm[5]) begin
          m_pend = 1;
          m_op   = m_frm[1];
          m_addr = m_frm[2];
          m_data = {m_frm[3], m_frm[4]};
        end else begin
          m_ec = 1;
        end
        m_frm.delete();
      end
    end else begin
      m_idle++;
      if (m_idle == TMO_I) begin
        m_et = 1;
        m_frm.delete();
      end
    end
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge.
  task automatic cyc(input bit rr, input logic [7:0] rd, input bit cr);
    bus.rx_ready  = rr;
    bus.rx_data   = rd;
    bus.cmd_ready = cr;
    model_step(rr, rd, cr);
    @(posedge clk); #1;
    check("cycle", outs(), model_outs());
    if (bus.err_checksum) obs_chk++;
    if (bus.err_timeout)  obs_tmo++;
    if (bus.err_overrun)  obs_ovr++;
  endtask

  task automatic idle(input int n, input bit cr);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), cr);
  endtask

  task automatic send6(input logic [47:0] f, input bit cr);
    for (int i = 5; i >= 0; i--) cyc(1'b1, f[i*8 +: 8], cr);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    bus.rx_ready = 1'b0; bus.cmd_ready = 1'b0; bus.rx_data = 8'h00;
    #1;
    check("reset_async", outs(), 36'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", outs(), 36'h0);
    reset = 1'b1;
  endtask

  initial begin
    int c0;
    reset = 1'b0;
    bus.rx_ready = 1'b0; bus.cmd_ready = 1'b0; bus.rx_data = 8'h00;
    model_reset();
    #1;
    apply_reset();

    // 1: good frame
    send6(48'hA5_01_10_12_34_37, 1'b0);
    check("t1_valid", bus.cmd_valid, 1);
    check("t1_fields", {bus.cmd_op, bus.cmd_addr, bus.cmd_data}, 32'h01_10_1234);
    check("t1_errs", {bus.err_checksum, bus.err_timeout, bus.err_overrun}, 3'b000);
    cyc(1'b0, 8'h00, 1'b1);
    check("t1_drop", bus.cmd_valid, 0);

    // 2: bad checksum, then good frame
    c0 = obs_chk;
    send6(48'hA5_01_10_12_34_38, 1'b0);
    check("t2_chk", bus.err_checksum, 1);
    check("t2_novalid", bus.cmd_valid, 0);
    cyc(1'b0, 8'h00, 1'b0);
    check("t2_pulse1", obs_chk - c0, 1);
    send6(48'hA5_01_10_12_34_37, 1'b1);
    check("t2_recover", bus.cmd_valid, 1);
    cyc(1'b0, 8'h00, 1'b1);

    // 3: timeout after two bytes, then good frame
    c0 = obs_tmo;
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b1, 8'h01, 1'b0);
    idle(TMO_I + 3, 1'b0);
    check("t3_tmo", obs_tmo - c0, 1);
    send6(48'hA5_02_20_00_FF_DD, 1'b0);
    check("t3_fields", {bus.cmd_valid, bus.cmd_op, bus.cmd_addr, bus.cmd_data}, 33'h1_02_20_00FF);

    // 4: overrun while pending
    c0 = obs_ovr;
    idle(2, 1'b0);
    cyc(1'b1, 8'h55, 1'b0);
    check("t4_ovr", bus.err_overrun, 1);
    check("t4_hold", {bus.cmd_valid, bus.cmd_op, bus.cmd_addr, bus.cmd_data}, 33'h1_02_20_00FF);
    cyc(1'b0, 8'h00, 1'b1);
    check("t4_drop", bus.cmd_valid, 0);
    check("t4_ovr_once", obs_ovr - c0, 1);

    // 5: noise then all-sync frame
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b1, 8'hA4, 1'b0);
    send6(48'hA5_A5_A5_A5_A5_00, 1'b0);
    check("t5_fields", {bus.cmd_valid, bus.cmd_op, bus.cmd_addr, bus.cmd_data}, 33'h1_A5_A5_A5A5);
    cyc(1'b0, 8'h00, 1'b1);

    // Expiry cycle coincides with a strobe: byte wins
    c0 = obs_tmo;
    cyc(1'b1, 8'hA5, 1'b0);
    idle(TMO_I - 1, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    check("edge_no_tmo", obs_tmo - c0, 0);
    idle(TMO_I + 1, 1'b0);

    // 6: reset mid-frame, then frame 1
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h10, 1'b0);
    apply_reset();
    send6(48'hA5_01_10_12_34_37, 1'b0);
    check("t6_fields", {bus.cmd_valid, bus.cmd_op, bus.cmd_addr, bus.cmd_data}, 33'h1_01_10_1234);
    cyc(1'b0, 8'h00, 1'b1);

    // Random traffic
    for (int t = 0; t < 250; t++) begin
      int kind, nb, gap, r;
      logic [7:0] b [6];
      kind = $urandom_range(0, 9);
      b[0] = SYNC;
      for (int i = 1; i < 5; i++) b[i] = 8'($urandom);
      b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
      if (kind == 6) b[5] = b[5] ^ 8'($urandom_range(1, 255));
      if (kind == 7) b[0] = 8'($urandom);
      nb = (kind == 8) ? $urandom_range(1, 5) : 6;
      for (int i = 0; i < nb; i++) begin
        r = $urandom_range(0, 19);
        if (r < 12)      gap = r % 3;
        else if (r < 16) gap = TMO_I - 1;
        else             gap = TMO_I;
        for (int g = 0; g < gap; g++) cyc(1'b0, 8'($urandom), 1'($urandom));
        cyc(1'b1, b[i], 1'($urandom));
      end
      if (kind == 8) idle(TMO_I + 1, 1'($urandom));
    end
    idle(3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
